// File: rtl/branch_seq_if.sv
// ---------------------------------------------------------------------------
// branch_seq_if -- request/bus/strobe bundle for the conditional-branch
// sequencer.
//
// Signals:
//   start              requester -> sequencer  execute one conditional branch
//   ir[31:0]           requester -> sequencer  instruction register (condition field inside)
//   bus[31:0]          datapath  -> sequencer  datapath bus, carries Ra during EVAL
//   ra_out, con_in     sequencer -> datapath   EVAL strobes
//   pc_out, y_in       sequencer -> datapath   ADDR1 strobes
//   c_out, alu_add, z_in  sequencer -> datapath   ADDR2 strobes
//   z_out, pc_in       sequencer -> datapath   WB strobes (pc_in only when taken)
//   busy, done, taken  sequencer status
//   taken_cnt, total_cnt  statistics counters (CNT_W bits each)
//
// Modports: master = requester/datapath side, slave = sequencer side.
// CNT_W must match the CNT_W of the branch_seq instance it connects to.
// ---------------------------------------------------------------------------
interface branch_seq_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      ir;
    logic [31:0]      bus;
    logic             ra_out;
    logic             con_in;
    logic             pc_out;
    logic             y_in;
    logic             c_out;
    logic             alu_add;
    logic             z_in;
    logic             z_out;
    logic             pc_in;
    logic             busy;
    logic             done;
    logic             taken;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] total_cnt;

    modport master (
        output start, ir, bus,
        input  ra_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
        input  z_out, pc_in, busy, done, taken, taken_cnt, total_cnt
    );

    modport slave (
        input  start, ir, bus,
        output ra_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
        output z_out, pc_in, busy, done, taken, taken_cnt, total_cnt
    );
endinterface

// File: rtl/branch_seq.sv
// ---------------------------------------------------------------------------
// branch_seq -- control sequencer for one conditional branch.
//
// Walks IDLE -> EVAL -> ADDR1 -> ADDR2 -> WB -> IDLE, one cycle per state.
// EVAL samples Ra from the bus and evaluates the 4-bit condition code taken
// from ir[COND_LSB+3:COND_LSB]; ADDR1/ADDR2 form PC+offset in Z; WB writes Z
// back to PC only when the branch is taken. Every strobe is a Moore decode
// of the state register, so timing is identical for taken and untaken
// branches.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bif    branch_seq_if.slave bundle (start/ir/bus in, strobes/status out)
//
// Parameters:
//   CNT_W     width of the statistics counters
//   COND_LSB  LSB of the condition field inside ir
//
// Optional feature: define BRANCH_STATS_EN to build saturating counters of
// completed (total_cnt) and taken (taken_cnt) branches; otherwise both read
// constant zero and no counter flops exist.
// ---------------------------------------------------------------------------
module branch_seq #(
    parameter int CNT_W    = 16,
    parameter int COND_LSB = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    branch_seq_if.slave bif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EVAL  = 3'd1,
        ADDR1 = 3'd2,
        ADDR2 = 3'd3,
        WB    = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        taken_r;
    logic [3:0]  cond_s;

    logic ra_out_s, con_in_s, pc_out_s, y_in_s, c_out_s, alu_add_s;
    logic z_in_s, z_out_s, pc_in_s, busy_s, done_s;

    // Condition evaluation on a signed Ra; codes 4..15 are never taken.
    function automatic logic cond_eval(input logic [3:0] code, input logic [31:0] ra);
        logic signed [31:0] ra_sv;
        logic               hit;
        ra_sv = $signed(ra);
        case (code)
            4'd0:    hit = (ra_sv == 32'sd0);
            4'd1:    hit = (ra_sv != 32'sd0);
            4'd2:    hit = (ra_sv >  32'sd0);
            4'd3:    hit = (ra_sv <  32'sd0);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign cond_s = bif.ir[COND_LSB+3:COND_LSB];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: only IDLE looks at start, the rest is a fixed walk.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bif.start) begin
                    state_nxt_s = EVAL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EVAL:    state_nxt_s = ADDR1;
            ADDR1:   state_nxt_s = ADDR2;
            ADDR2:   state_nxt_s = WB;
            WB:      state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Condition flag: captured at the end of EVAL, held until the next EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_r <= 1'b0;
        end else if (state_r == EVAL) begin
            taken_r <= cond_eval(cond_s, bif.bus);
        end else begin
            taken_r <= taken_r;
        end
    end

    // Moore strobe decode; each state enables at most one bus driver.
    always_comb begin
        ra_out_s  = 1'b0;
        con_in_s  = 1'b0;
        pc_out_s  = 1'b0;
        y_in_s    = 1'b0;
        c_out_s   = 1'b0;
        alu_add_s = 1'b0;
        z_in_s    = 1'b0;
        z_out_s   = 1'b0;
        pc_in_s   = 1'b0;
        done_s    = 1'b0;
        busy_s    = (state_r != IDLE);
        case (state_r)
            EVAL: begin
                ra_out_s = 1'b1;
                con_in_s = 1'b1;
            end
            ADDR1: begin
                pc_out_s = 1'b1;
                y_in_s   = 1'b1;
            end
            ADDR2: begin
                c_out_s   = 1'b1;
                alu_add_s = 1'b1;
                z_in_s    = 1'b1;
            end
            WB: begin
                z_out_s = 1'b1;
                done_s  = 1'b1;
                pc_in_s = taken_r;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bif.ra_out  = ra_out_s;
    assign bif.con_in  = con_in_s;
    assign bif.pc_out  = pc_out_s;
    assign bif.y_in    = y_in_s;
    assign bif.c_out   = c_out_s;
    assign bif.alu_add = alu_add_s;
    assign bif.z_in    = z_in_s;
    assign bif.z_out   = z_out_s;
    assign bif.pc_in   = pc_in_s;
    assign bif.busy    = busy_s;
    assign bif.done    = done_s;
    assign bif.taken   = taken_r;

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] total_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;

    // Saturating statistics, bumped once per WB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt_r <= '0;
            taken_cnt_r <= '0;
        end else if (state_r == WB) begin
            if (total_cnt_r != CNT_MAX) begin
                total_cnt_r <= total_cnt_r + CNT_ONE;
            end else begin
                total_cnt_r <= total_cnt_r;
            end
            if (taken_r && (taken_cnt_r != CNT_MAX)) begin
                taken_cnt_r <= taken_cnt_r + CNT_ONE;
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end else begin
            total_cnt_r <= total_cnt_r;
            taken_cnt_r <= taken_cnt_r;
        end
    end

    assign bif.total_cnt = total_cnt_r;
    assign bif.taken_cnt = taken_cnt_r;
`else
    assign bif.total_cnt = '0;
    assign bif.taken_cnt = '0;
`endif

endmodule

// File: doc/branch_seq.md
BRANCH_SEQ -- requirements
Module: branch_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of each statistics counter.
REQ-002 Parameter COND_LSB, default 19: LSB of the 4-bit condition field within ir; field is ir[COND_LSB+3:COND_LSB].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  request to execute one conditional branch; sampled only in IDLE.
REQ-006 ir  input  32  instruction register; held stable by the requester from start acceptance until done.
REQ-007 bus  input  32  datapath bus, signed two's complement; carries Ra during EVAL.
REQ-008 ra_out  output  1  strobe: drive Ra onto bus.
REQ-009 con_in  output  1  strobe: condition flag samples bus at the end of this cycle.
REQ-010 pc_out, y_in  output  1 each  strobes: PC onto bus, Y latches bus.
REQ-011 c_out, alu_add, z_in  output  1 each  strobes: offset constant onto bus, ALU add, Z latches result.
REQ-012 z_out, pc_in  output  1 each  strobes: Z onto bus, PC latches bus.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse in the final cycle of a branch.
REQ-015 taken  output  1  registered condition result of the most recent branch.
REQ-016 taken_cnt, total_cnt  output  CNT_W each  statistics counters (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, EVAL, ADDR1, ADDR2, WB; encoding is free.
REQ-018 IDLE -> EVAL on a clock edge where start=1; otherwise stay in IDLE.
REQ-019 EVAL -> ADDR1 -> ADDR2 -> WB -> IDLE unconditionally, one cycle each; start SHALL be ignored outside IDLE.
REQ-020 Latency SHALL be fixed: done goes high exactly 4 cycles after the edge that accepts start; back-to-back branches SHALL be accepted on the edge that returns the FSM to IDLE only if start=1 in the following IDLE cycle (minimum 5 cycles per branch).
REQ-021 EVAL SHALL assert ra_out and con_in; ADDR1 SHALL assert pc_out and y_in; ADDR2 SHALL assert c_out, alu_add and z_in; WB SHALL assert z_out and done, and pc_in only if taken=1.
REQ-022 All strobes SHALL be decoded from the registered state only (Moore); at most one bus driver (ra_out, pc_out, c_out, z_out) SHALL be high in any cycle.
REQ-023 Condition codes: 0 taken iff bus==0; 1 taken iff bus!=0; 2 taken iff bus>0 (signed, zero not taken); 3 taken iff bus<0 (signed); 4-15 never taken.
REQ-024 taken SHALL update only at the end of EVAL and hold its value until the next EVAL.
REQ-025 An untaken branch SHALL still traverse all states with identical timing; only pc_in is suppressed.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, all strobes 0, busy 0, done 0, taken 0, taken_cnt 0, total_cnt 0.
REQ-027 Reset asserted mid-branch SHALL abort it with no pc_in pulse; after release the FSM accepts start on the first rising edge with rst_n=1.

Configuration
REQ-028 With BRANCH_STATS_EN defined, total_cnt SHALL increment in every WB cycle and taken_cnt in every WB cycle with taken=1; both SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Without BRANCH_STATS_EN, taken_cnt and total_cnt SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-030 Code 0, bus=0 -> strobe sequence EVAL/ADDR1/ADDR2/WB over 4 cycles, taken=1, pc_in=1 in WB, done 4 cycles after start.
REQ-031 Code 1, bus=0 -> taken=0, pc_in stays 0 throughout, done still 4 cycles after start.
REQ-032 Code 2: bus=4 -> taken=1; bus=0 -> taken=0; bus=-4 -> taken=0. Code 3: bus=-4 -> taken=1; bus=4 -> taken=0.
REQ-033 Code 9, bus=7 -> taken=0; start pulsed during ADDR1 -> ignored, single done pulse, busy low the cycle after WB.
REQ-034 rst_n pulled low during ADDR2 -> all outputs 0 immediately, no pc_in pulse; next start completes a normal branch.
REQ-035 BRANCH_STATS_EN, CNT_W=2: five taken branches -> total_cnt=3, taken_cnt=3 (saturated); without macro both read 0.
